// File: rtl/mult_dispatch_if.sv
// Operand/multiplier/result bundle for mult_dispatch.
// master = dispatcher side, slave = environment side.
interface mult_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic        mul_start;
  logic [15:0] mul_result;
  logic        mul_ready;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;

  modport master (
    input  in_valid, in_x, in_y,
    input  mul_result, mul_ready,
    input  res_ready,
    output in_ready, mul_x, mul_y, mul_start,
    output res_valid, res_data, res_err
  );

  modport slave (
    output in_valid, in_x, in_y,
    output mul_result, mul_ready,
    output res_ready,
    input  in_ready, mul_x, mul_y, mul_start,
    input  res_valid, res_data, res_err
  );
endinterface

// File: rtl/mult_dispatch.sv
// Stream front-end for the 8x8 sequential multiplier with timeout abort.
// Optional result accumulator: define MULT_DISPATCH_ACC_EN.
module mult_dispatch #(
  parameter int GUARD_CYC = 2,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  mult_dispatch_if.master  io,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
`ifdef MULT_DISPATCH_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [23:0]      acc_data
`endif
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, START, WAIT, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [7:0]       mx_q, mx_d;
  logic [7:0]       my_q, my_d;
  logic             rv_q, rv_d;
  logic [15:0]      rd_q, rd_d;
  logic             re_q, re_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;
  logic             tmo;
  logic             hs;

  // ready may still be high from the previous product right after start
  assign hit = io.mul_ready && (wcnt_q >= WC_W'(GUARD_CYC));
  assign tmo = (wcnt_q == WC_W'(TIMEOUT - 1));
  assign hs  = (state_q == DONE) && io.res_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    mx_d    = mx_q;
    my_d    = my_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    re_d    = re_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          mx_d    = io.in_x;
          my_d    = io.in_y;
          state_d = START;
        end
      end
      START: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (hit) begin
          rd_d    = io.mul_result;
          re_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = DONE;
        end else if (tmo) begin
          rd_d    = 16'hFFFF;
          re_d    = 1'b1;
          rv_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.res_ready) begin
          rv_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      re_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      re_q    <= re_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.mul_start = (state_q == START);
  assign io.mul_x     = mx_q;
  assign io.mul_y     = my_q;
  assign io.res_valid = rv_q;
  assign io.res_data  = rd_q;
  assign io.res_err   = re_q;
  assign busy         = (state_q != IDLE);
  assign op_count     = cnt_q;

`ifdef MULT_DISPATCH_ACC_EN
  logic [23:0] acc_q, acc_d;

  // clear and accumulate compose: a clear with a handshake loads the product
  always_comb begin
    acc_d = acc_clr ? 24'h0 : acc_q;
    if (hs && !re_q)
      acc_d = acc_d + {8'h0, rd_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_data = acc_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_mult_dispatch.sv
// Randomized self-checking bench for mult_dispatch with a
// behavioural sequential-multiplier model.
module tb_mult_dispatch;
  localparam int GUARD = 2;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [7:0] op_count;
`ifdef MULT_DISPATCH_ACC_EN
  logic        acc_clr;
  logic [23:0] acc_data;
`endif

  always #5 clk = ~clk;

  mult_dispatch_if mif ();

  mult_dispatch #(
    .GUARD_CYC(GUARD),
    .TIMEOUT  (TMO),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io      (mif.master),
    .busy    (busy),
    .op_count(op_count)
`ifdef MULT_DISPATCH_ACC_EN
    ,
    .acc_clr (acc_clr),
    .acc_data(acc_data)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0]  exp_cnt = 8'h0;
  logic [23:0] exp_acc = 24'h0;

  // multiplier model: ready m_lat cycles after start, stale ready for m_stale
  int          m_lat   = 9;
  int          m_stale = 0;
  bit          m_stuck = 1'b0;
  int          mt      = 1000;
  logic [7:0]  mx      = 8'h0;
  logic [7:0]  my      = 8'h0;
  logic [15:0] m_prev  = 16'h0;
  logic [15:0] prod;

  assign prod = {8'h0, mx} * {8'h0, my};

  always @(posedge clk) begin
    if (mif.mul_start) begin
      m_prev <= prod;
      mx     <= mif.mul_x;
      my     <= mif.mul_y;
      mt     <= 0;
    end else if (mt < 1000) begin
      mt <= mt + 1;
    end
  end

  assign mif.mul_ready  = !m_stuck && (mt < m_stale || mt >= m_lat);
  assign mif.mul_result = (mt >= m_lat) ? prod : m_prev;

  function automatic int exp_lat(input int lat);
    return 2 + ((lat > GUARD) ? lat : GUARD);
  endfunction

  task automatic do_op(
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  int          hold,
    input  bit          clr,
    output logic [15:0] d,
    output logic        e,
    output int          lat,
    output int          starts,
    output bit          stable
  );
    int k;
    mif.in_x     = x;
    mif.in_y     = y;
    mif.in_valid = 1'b1;
    k = 0;
    while (!mif.in_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    mif.in_x     = 8'($urandom);
    mif.in_y     = 8'($urandom);
    lat    = 0;
    starts = 0;
    while (!mif.res_valid && lat < 200) begin
      if (mif.mul_start) starts++;
      @(posedge clk); #1; lat++;
    end
    if (!mif.res_valid) lat = -1;
    d      = mif.res_data;
    e      = mif.res_err;
    stable = 1'b1;
    if (mif.mul_x !== x || mif.mul_y !== y) stable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (mif.in_ready || !mif.res_valid || mif.mul_start ||
          mif.res_data !== d || mif.res_err !== e)
        stable = 1'b0;
    end
    mif.res_ready = 1'b1;
`ifdef MULT_DISPATCH_ACC_EN
    acc_clr = clr;
`endif
    @(posedge clk); #1;
    mif.res_ready = 1'b0;
`ifdef MULT_DISPATCH_ACC_EN
    acc_clr = 1'b0;
`endif
    if (lat >= 0) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mif.in_valid = 1'b0;
    mif.in_x = 8'h0;
    mif.in_y = 8'h0;
    mif.res_ready = 1'b0;
`ifdef MULT_DISPATCH_ACC_EN
    acc_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mif.in_ready !== 1'b1 || mif.res_valid !== 1'b0 ||
        mif.mul_start !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl in_ready=%b res_valid=%b start=%b busy=%b exp 1/0/0/0",
               mif.in_ready, mif.res_valid, mif.mul_start, busy);
    end
    checks++;
    if (mif.mul_x !== 8'h0 || mif.mul_y !== 8'h0 ||
        mif.res_data !== 16'h0 || mif.res_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_data mul_x=%h mul_y=%h res_data=%h err=%b exp zero",
               mif.mul_x, mif.mul_y, mif.res_data, mif.res_err);
    end
    checks++;
    if (op_count !== 8'h0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=0", op_count);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] d; logic e; int lat, st; bit stb;
    m_lat = 9; m_stale = 0; m_stuck = 1'b0;
    do_op(8'd20, 8'd10, 0, 1'b0, d, e, lat, st, stb);
    checks++;
    if (d !== 16'd200 || e !== 1'b0) begin
      failures++;
      $display("FAIL basic_data got=%0d err=%b exp=200 err=0", d, e);
    end
    checks++;
    if (st != 1 || lat != exp_lat(9)) begin
      failures++;
      $display("FAIL basic_timing starts=%0d lat=%0d exp 1/%0d",
               st, lat, exp_lat(9));
    end
    checks++;
    if (op_count !== exp_cnt || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_cnt got=%0d busy=%b exp=%0d busy=0",
               op_count, busy, exp_cnt);
    end
  endtask

  task automatic test_stale();
    logic [15:0] d; logic e; int lat, st; bit stb;
    m_lat = 9; m_stale = 1;
    do_op(8'd255, 8'd255, 0, 1'b0, d, e, lat, st, stb);
    m_stale = 0;
    checks++;
    if (d !== 16'd65025 || e !== 1'b0 || lat != exp_lat(9)) begin
      failures++;
      $display("FAIL stale_ready got=%0d err=%b lat=%0d exp=65025 err=0 lat=%0d",
               d, e, lat, exp_lat(9));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic e; int lat, st; bit stb;
    m_lat = 5;
    do_op(8'd37, 8'd0, 5, 1'b0, d, e, lat, st, stb);
    checks++;
    if (d !== 16'd0 || e !== 1'b0 || !stb) begin
      failures++;
      $display("FAIL b2b_first got=%0d err=%b stable=%b exp=0 err=0 stable=1",
               d, e, stb);
    end
    do_op(8'd0, 8'd96, 5, 1'b0, d, e, lat, st, stb);
    checks++;
    if (d !== 16'd0 || e !== 1'b0 || !stb) begin
      failures++;
      $display("FAIL b2b_second got=%0d err=%b stable=%b exp=0 err=0 stable=1",
               d, e, stb);
    end
    checks++;
    if (op_count !== exp_cnt) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d exp=%0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] d; logic e; int lat, st; bit stb;
    m_stuck = 1'b1;
    do_op(8'd3, 8'd4, 2, 1'b0, d, e, lat, st, stb);
    m_stuck = 1'b0;
    checks++;
    if (d !== 16'hFFFF || e !== 1'b1 || !stb) begin
      failures++;
      $display("FAIL timeout_data got=%h err=%b stable=%b exp=ffff err=1",
               d, e, stb);
    end
    checks++;
    if (lat != 1 + TMO) begin
      failures++;
      $display("FAIL timeout_lat got=%0d exp=%0d", lat, 1 + TMO);
    end
    m_lat = 9;
    do_op(8'd1, 8'd67, 0, 1'b0, d, e, lat, st, stb);
    checks++;
    if (d !== 16'd67 || e !== 1'b0 || op_count !== exp_cnt) begin
      failures++;
      $display("FAIL timeout_next got=%0d err=%b cnt=%0d exp=67 err=0 cnt=%0d",
               d, e, op_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic e; int lat, st; bit stb;
    m_lat = 20;
    mif.in_x = 8'd96; mif.in_y = 8'd1; mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || op_count === 8'h0) begin
      failures++;
      $display("FAIL rstmid_pre busy=%b cnt=%0d exp busy=1 cnt>0",
               busy, op_count);
    end
    reset = 1'b0;
    #1;
    exp_cnt = 8'h0;
    exp_acc = 24'h0;
    checks++;
    if (mif.in_ready !== 1'b1 || mif.res_valid !== 1'b0 ||
        op_count !== 8'h0 || mif.mul_start !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async in_ready=%b res_valid=%b cnt=%0d start=%b busy=%b exp 1/0/0/0/0",
               mif.in_ready, mif.res_valid, op_count, mif.mul_start, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    m_lat = 9;
    do_op(8'd96, 8'd1, 0, 1'b0, d, e, lat, st, stb);
    checks++;
    if (d !== 16'd96 || e !== 1'b0 || op_count !== 8'd1) begin
      failures++;
      $display("FAIL rstmid_next got=%0d err=%b cnt=%0d exp=96 err=0 cnt=1",
               d, e, op_count);
    end
    exp_acc = 24'd96;
  endtask

`ifdef MULT_DISPATCH_ACC_EN
  task automatic test_acc();
    logic [15:0] d; logic e; int lat, st; bit stb;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_cnt = 8'h0;
    @(posedge clk); #1;
    checks++;
    if (acc_data !== 24'h0) begin
      failures++;
      $display("FAIL acc_reset got=%0d exp=0", acc_data);
    end
    m_lat = 9;
    do_op(8'd20, 8'd10, 0, 1'b0, d, e, lat, st, stb);
    do_op(8'd255, 8'd255, 1, 1'b0, d, e, lat, st, stb);
    checks++;
    if (acc_data !== 24'd65225) begin
      failures++;
      $display("FAIL acc_sum got=%0d exp=65225", acc_data);
    end
    do_op(8'd1, 8'd67, 0, 1'b1, d, e, lat, st, stb);
    checks++;
    if (acc_data !== 24'd67) begin
      failures++;
      $display("FAIL acc_clr got=%0d exp=67", acc_data);
    end
    m_stuck = 1'b1;
    do_op(8'd9, 8'd9, 0, 1'b0, d, e, lat, st, stb);
    m_stuck = 1'b0;
    checks++;
    if (acc_data !== 24'd67 || e !== 1'b1) begin
      failures++;
      $display("FAIL acc_err got=%0d err=%b exp=67 err=1", acc_data, e);
    end
    exp_acc = 24'd67;
  endtask
`endif

  task automatic test_random();
    logic [15:0] d, xd;
    logic e, xe;
    int lat, st, xl, bad;
    bit stb, clr;
    logic [7:0] x, y;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      m_lat   = $urandom_range(0, 14);
      m_stale = $urandom_range(0, GUARD);
      m_stuck = ($urandom_range(0, 7) == 0);
      clr     = ($urandom_range(0, 5) == 0);
      if (m_stuck) begin
        xd = 16'hFFFF; xe = 1'b1; xl = 1 + TMO;
      end else begin
        xd = 16'(x) * 16'(y); xe = 1'b0; xl = exp_lat(m_lat);
      end
      do_op(x, y, $urandom_range(0, 3), clr, d, e, lat, st, stb);
      if (clr) exp_acc = 24'h0;
      if (!xe) exp_acc = exp_acc + 24'(xd);
      checks++;
      if (d !== xd || e !== xe || lat != xl || st != 1 || !stb) begin
        failures++; bad++;
        if (bad < 5)
          $display("FAIL rand_op %0dx%0d got=%0d err=%b lat=%0d st=%0d stb=%b exp=%0d err=%b lat=%0d",
                   x, y, d, e, lat, st, stb, xd, xe, xl);
      end
      checks++;
      if (op_count !== exp_cnt) begin
        failures++;
        $display("FAIL rand_cnt got=%0d exp=%0d", op_count, exp_cnt);
      end
`ifdef MULT_DISPATCH_ACC_EN
      checks++;
      if (acc_data !== exp_acc) begin
        failures++;
        $display("FAIL rand_acc got=%0d exp=%0d", acc_data, exp_acc);
      end
`endif
    end
    m_stuck = 1'b0;
    m_stale = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef MULT_DISPATCH_ACC_EN
    test_acc();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mult_dispatch.md
Name: mult_dispatch

Overview:
- Upstream operand dispatcher for the 8x8 sequential multiplier.
- Accepts operand pairs over a valid/ready stream and drives the multiplier's x/y/start interface.
- Waits for the multiplier's ready, captures the 16-bit product and presents it downstream on a valid/ready result port.
- Converts the multiplier's start-by-pulse interface into a clean streaming stage, with timeout protection.

Parameters:
- GUARD_CYC, 2: cycles after the start pulse during which mul_ready is ignored, because ready may still be high from the previous product.
- TIMEOUT, 64: maximum WAIT cycles before the operation is aborted with an error.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset: asserts immediately, deasserts synchronously to clk at the user level.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  dispatcher can accept operands.
- in_x  in  8  multiplicand.
- in_y  in  8  multiplier operand.
- mul_x  out  8  to multiplier x.
- mul_y  out  8  to multiplier y.
- mul_start  out  1  to the multiplier's active-high start/reset input; one-cycle pulse.
- mul_result  in  16  product from the multiplier.
- mul_ready  in  1  multiplier done.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  16  captured product.
- res_err  out  1  result is a timeout abort; res_data=16'hFFFF.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  completed operations, including errors; wraps modulo 2^CNT_W.

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE.
- All outputs 0, except in_ready=1.
- mul_x, mul_y, res_data, op_count, wait counter all 0.

FSM states: IDLE, START, WAIT, DONE.

IDLE:
- in_ready=1.
- On in_valid: register in_x->mul_x and in_y->mul_y; go to START.
- Operands are held stable on mul_x/mul_y until the next accept.

START:
- mul_start=1 for exactly this one cycle; in_ready=0.
- Clear the wait counter; go to WAIT.

WAIT:
- Increment the wait counter each cycle.
- mul_ready is ignored while wait counter < GUARD_CYC.
- If mul_ready=1 and wait counter >= GUARD_CYC: res_data<=mul_result, res_err<=0, res_valid<=1; go to DONE.
- Else, if wait counter == TIMEOUT-1: res_data<=16'hFFFF, res_err<=1, res_valid<=1; go to DONE.
- If both conditions hold in the same cycle, the valid mul_ready wins.

DONE:
- res_valid=1; res_data and res_err held stable.
- On res_ready: res_valid<=0, op_count<=op_count+1; go to IDLE.
- in_ready is 0 in DONE. Throughput is therefore one operation per (2 + multiplier latency + 1 + handshake) cycles; no overlap.

Latency:
- in_valid accept to res_valid = 2 + N cycles, where N = cycle index in WAIT at which qualifying mul_ready is seen (N >= GUARD_CYC).

Other rules:
- res_valid, once high, never drops without res_ready (AXI-style stability).
- in_valid while in_ready=0 is ignored; the upstream must hold it.
- Reset mid-operation returns to IDLE immediately, with no result emitted and op_count cleared. mul_start drops asynchronously.
- op_count wraps from 2^CNT_W-1 to 0.
- Product width is 16 bits and is never truncated.

Optional Feature:
Macro: MULT_DISPATCH_ACC_EN
- Defined:
  - Adds output acc_data (24 bits) and input acc_clr (1 bit).
  - On each res_ready handshake with res_err=0, acc_data<=acc_data+res_data, wrapping modulo 2^24.
  - Error results are not accumulated.
  - acc_clr=1 zeroes acc_data synchronously; if it coincides with a handshake, acc_data<=res_data.
  - Reset zeroes acc_data.
- Undefined: acc_data and acc_clr do not exist; everything else is identical.

Test Plan:
- 20x10, multiplier model with 9-cycle latency, res_ready=1 -> res_data=200, res_err=0, one mul_start pulse, op_count=1, busy low after the handshake.
- 255x255 -> res_data=65025. Model holds mul_ready high from the previous op for 1 cycle after start -> stale ready ignored, correct product captured.
- 37x0 then 0x96 back-to-back, res_ready held 0 for 5 cycles after each res_valid -> res_data=0 held stable, in_ready=0 throughout, op_count=2 after both handshakes.
- mul_ready stuck 0, operands 3x4 -> res_valid exactly TIMEOUT cycles after entering WAIT, res_data=16'hFFFF, res_err=1. Next op 1x67 -> 67 with res_err=0.
- reset asserted 4 cycles into WAIT of 96x1 -> in_ready=1, res_valid=0, op_count=0 in the same cycle. Subsequent 96x1 -> 96.
- With MULT_DISPATCH_ACC_EN: 20x10 then 255x255 -> acc_data=65225. acc_clr pulsed with a third result 1x67 -> acc_data=67.
